// File: rtl/srl_fifo_fwft_pkg.sv
// -----------------------------------------------------------------------------
// srl_fifo_fwft_pkg
// Shared definitions for the shift-register FWFT FIFO:
//   - SRL_DEPTH_16 / SRL_DEPTH_32 : the two depths the SRL primitives map onto
//   - clog2()                     : constant ceiling-log2 for address widths
//   - depth_supported()           : elaboration-time depth legality check
// No ports (package).
// -----------------------------------------------------------------------------
package srl_fifo_fwft_pkg;

    localparam int SRL_DEPTH_16 = 16;
    localparam int SRL_DEPTH_32 = 32;

    // Ceiling log2; clog2(1) = 0, clog2(16) = 4, clog2(17) = 5.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

    // Only depths that map 1:1 onto a single SRL16E or SRLC32E per bit.
    function automatic bit depth_supported(input int depth);
        return (depth == SRL_DEPTH_16) || (depth == SRL_DEPTH_32);
    endfunction

endpackage

// File: rtl/srl_fifo_fwft_shift_mem.sv
// -----------------------------------------------------------------------------
// srl_shift_mem
// WIDTH x DEPTH shift-register memory, one DEPTH-long shift chain per data bit
// so that each bit maps onto a single SRL16E / SRLC32E.
// Ports:
//   clk   in  1      rising-edge clock
//   ce    in  1      shift enable: din enters index 0, all words move up one
//   din   in  WIDTH  word shifted in at index 0
//   addr  in  AW     asynchronous read address (0 = newest word)
//   dout  out WIDTH  word at index addr, combinational from current contents
// Contents are deliberately not reset; the owning FIFO tracks what is valid.
// -----------------------------------------------------------------------------
module srl_shift_mem
    import srl_fifo_fwft_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = SRL_DEPTH_16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] dout
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [DEPTH-1:0] sr_q;
        logic [DEPTH-1:0] sr_d;

        always_comb begin
            sr_d = sr_q;
            if (ce) begin
                sr_d = {sr_q[DEPTH-2:0], din[b]};
            end
        end

        always_ff @(posedge clk) begin
            sr_q <= sr_d;
        end

        assign dout[b] = sr_q[addr];
    end

endmodule

// File: rtl/srl_fifo_fwft.sv
// -----------------------------------------------------------------------------
// srl_fifo_fwft
// Parametrised shift-register FIFO with a registered first-word-fall-through
// output stage. Capacity is DEPTH+1 words: DEPTH in the SRL plus one in the
// output register, which also hides the asynchronous SRL read path.
// Ports:
//   clk    in  1      rising-edge clock
//   rst    in  1      synchronous active-high reset (clears everything)
//   clr    in  1      synchronous flush; like rst but ovf/udf are kept
//   din    in  WIDTH  write data
//   iv     in  1      input valid; accepted when iv & rfd
//   rfd    out 1      ready for data (= ~full)
//   dout   out WIDTH  head-of-FIFO word, valid while ov
//   ov     out 1      output valid
//   oe     in  1      consumer accepts dout; pop when ov & oe
//   level  out AW+1   words held (SRL count + ov)
//   empty  out 1      level == 0
//   full   out 1      level == DEPTH+1
//   afull  out 1      level >= AFULL_LVL
//   ovf    out 1      sticky: iv seen while full
//   udf    out 1      sticky: oe seen while ~ov
// -----------------------------------------------------------------------------
module srl_fifo_fwft
    import srl_fifo_fwft_pkg::*;
#(
    parameter  int WIDTH     = 36,
    parameter  int DEPTH     = SRL_DEPTH_16,
    parameter  int AFULL_LVL = DEPTH - 1,
    localparam int AW        = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             iv,
    output logic             rfd,
    output logic [WIDTH-1:0] dout,
    output logic             ov,
    input  logic             oe,
    output logic [AW:0]      level,
    output logic             empty,
    output logic             full,
    output logic             afull,
    output logic             ovf,
    output logic             udf
);

    localparam int          LW       = AW + 1;
    localparam logic [AW:0] FULL_LVL = LW'(DEPTH + 1);
    localparam logic [AW:0] AF_LVL   = LW'(AFULL_LVL);

    if (!depth_supported(DEPTH)) begin : g_depth_check
        $error("srl_fifo_fwft: DEPTH must be 16 or 32");
    end

    logic [AW:0]      srl_cnt_q, srl_cnt_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic [AW:0]      level_w;
    logic             full_w;
    logic             we;
    logic             ld;
    logic             pop;
    logic             srl_ce;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] srl_rd;

    // Occupancy and flags come only from registered state, so there is no
    // combinational path from iv/oe to rfd or any other flag.
    assign level_w = srl_cnt_q + {{AW{1'b0}}, ov_q};
    assign full_w  = (level_w == FULL_LVL);

    assign we  = iv & ~full_w;
    assign ld  = (srl_cnt_q != '0) & (~ov_q | oe);
    assign pop = ov_q & oe;

    // Flush/reset cycles must not disturb the SRL even if iv is high.
    assign srl_ce = we & ~rst & ~clr;

    // Oldest word sits at index srl_cnt-1. At srl_cnt == DEPTH the low AW bits
    // wrap to 0 and the subtraction lands on DEPTH-1, as required. The read
    // uses pre-edge contents, so a simultaneous shift cannot reorder data.
    assign rd_addr = srl_cnt_q[AW-1:0] - AW'(1);

    srl_shift_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk  (clk),
        .ce   (srl_ce),
        .din  (din),
        .addr (rd_addr),
        .dout (srl_rd)
    );

    always_comb begin
        srl_cnt_d = srl_cnt_q;
        ov_d      = ov_q;
        dout_d    = dout_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;

        if (rst) begin
            srl_cnt_d = '0;
            ov_d      = 1'b0;
            dout_d    = '0;
            ovf_d     = 1'b0;
            udf_d     = 1'b0;
        end else if (clr) begin
            srl_cnt_d = '0;
            ov_d      = 1'b0;
            dout_d    = '0;
        end else begin
            // Write and load together leave the SRL count unchanged.
            unique case ({we, ld})
                2'b10:   srl_cnt_d = srl_cnt_q + LW'(1);
                2'b01:   srl_cnt_d = srl_cnt_q - LW'(1);
                default: srl_cnt_d = srl_cnt_q;
            endcase

            // A pop with nothing to refill drops ov; dout keeps its last word.
            if (ld) begin
                dout_d = srl_rd;
                ov_d   = 1'b1;
            end else if (pop) begin
                ov_d   = 1'b0;
            end

            if (iv & full_w) begin
                ovf_d = 1'b1;
            end
            if (oe & ~ov_q) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        srl_cnt_q <= srl_cnt_d;
        ov_q      <= ov_d;
        dout_q    <= dout_d;
        ovf_q     <= ovf_d;
        udf_q     <= udf_d;
    end

    assign level = level_w;
    assign full  = full_w;
    assign rfd   = ~full_w;
    assign empty = (level_w == '0);
    assign afull = (level_w >= AF_LVL);
    assign ov    = ov_q;
    assign dout  = dout_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: tb/tb_srl_fifo_fwft.sv
// -----------------------------------------------------------------------------
// tb_srl_fifo_fwft
// Directed bench for srl_fifo_fwft (WIDTH=36, DEPTH=16, AFULL_LVL=15):
// reset state, FWFT latency, fill to full with overflow, ordered drain with
// underflow, continuous streaming, and flush/reset behaviour.
// -----------------------------------------------------------------------------
module tb_srl_fifo_fwft;

    localparam int WIDTH     = 36;
    localparam int DEPTH     = 16;
    localparam int AFULL_LVL = 15;
    localparam int LW        = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic [WIDTH-1:0] din;
    logic             iv;
    logic             rfd;
    logic [WIDTH-1:0] dout;
    logic             ov;
    logic             oe;
    logic [LW-1:0]    level;
    logic             empty;
    logic             full;
    logic             afull;
    logic             ovf;
    logic             udf;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] head;

    always #5 clk = ~clk;

    srl_fifo_fwft #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .din   (din),
        .iv    (iv),
        .rfd   (rfd),
        .dout  (dout),
        .ov    (ov),
        .oe    (oe),
        .level (level),
        .empty (empty),
        .full  (full),
        .afull (afull),
        .ovf   (ovf),
        .udf   (udf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        iv  = 1'b0;
        oe  = 1'b0;
        din = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // 1. reset then idle
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_rfd",   64'(rfd),   64'(1));
        chk("rst_full",  64'(full),  64'(0));
        chk("rst_afull", 64'(afull), 64'(0));
        chk("rst_ov",    64'(ov),    64'(0));
        chk("rst_dout",  64'(dout),  64'(0));
        chk("rst_ovf",   64'(ovf),   64'(0));
        chk("rst_udf",   64'(udf),   64'(0));

        // 2. single write, FWFT latency
        din = 36'h0_0000_00A5;
        iv  = 1'b1;
        step();
        iv  = 1'b0;
        chk("lat1_ov",    64'(ov),    64'(0));
        chk("lat1_level", 64'(level), 64'(1));
        chk("lat1_empty", 64'(empty), 64'(0));
        step();
        chk("lat2_ov",    64'(ov),    64'(1));
        chk("lat2_dout",  64'(dout),  64'h0A5);
        chk("lat2_level", 64'(level), 64'(1));
        oe = 1'b1;
        step();
        oe = 1'b0;
        chk("pop1_ov",    64'(ov),    64'(0));
        chk("pop1_empty", 64'(empty), 64'(1));
        chk("pop1_dout",  64'(dout),  64'h0A5);
        chk("pop1_udf",   64'(udf),   64'(0));

        // 3. fill with 1..17, then overflow attempt
        for (int i = 1; i <= 17; i++) begin
            din = WIDTH'(i);
            iv  = 1'b1;
            step();
            chk("fill_level", 64'(level), 64'(i));
            chk("fill_afull", 64'(afull), 64'(i >= 15));
            chk("fill_full",  64'(full),  64'(i == 17));
            chk("fill_rfd",   64'(rfd),   64'(i != 17));
        end
        din = WIDTH'(18);
        step();
        iv = 1'b0;
        chk("ovf_level", 64'(level), 64'(17));
        chk("ovf_flag",  64'(ovf),   64'(1));
        chk("ovf_full",  64'(full),  64'(1));

        // 4. drain from full, order and underflow
        oe = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            chk("drain_ov",   64'(ov),   64'(1));
            chk("drain_dout", 64'(dout), 64'(k));
            step();
            if (k == 1) begin
                chk("drain_rfd",   64'(rfd),   64'(1));
                chk("drain_level", 64'(level), 64'(16));
            end
        end
        chk("drained_ov",    64'(ov),    64'(0));
        chk("drained_empty", 64'(empty), 64'(1));
        chk("drained_udf",   64'(udf),   64'(0));
        step();
        oe = 1'b0;
        chk("udf_flag",  64'(udf),   64'(1));
        chk("udf_dout",  64'(dout),  64'(17));
        chk("udf_level", 64'(level), 64'(0));

        // 5. streaming: prefill 3 words, then iv & oe every cycle
        for (int i = 0; i < 3; i++) begin
            w   = {4'($urandom()), 32'($urandom())};
            din = w;
            exp_q.push_back(w);
            iv  = 1'b1;
            step();
        end
        iv = 1'b0;
        chk("pre_level", 64'(level), 64'(3));
        chk("pre_ov",    64'(ov),    64'(1));
        for (int i = 0; i < 20; i++) begin
            w   = {4'($urandom()), 32'($urandom())};
            din = w;
            exp_q.push_back(w);
            iv  = 1'b1;
            oe  = 1'b1;
            head = exp_q.pop_front();
            chk("stream_dout",  64'(dout),  64'(head));
            chk("stream_ov",    64'(ov),    64'(1));
            chk("stream_level", 64'(level), 64'(3));
            step();
        end
        iv = 1'b0;
        oe = 1'b0;
        head = exp_q.pop_front();
        chk("stream_end_level", 64'(level), 64'(3));
        chk("stream_end_dout",  64'(dout),  64'(head));

        // 6. clr at level 9 with iv high
        for (int i = 0; i < 6; i++) begin
            din = WIDTH'(36'h100 + i);
            iv  = 1'b1;
            step();
        end
        iv = 1'b0;
        chk("pre_clr_level", 64'(level), 64'(9));
        clr = 1'b1;
        iv  = 1'b1;
        din = 36'hF_DEAD_BEEF;
        step();
        clr = 1'b0;
        iv  = 1'b0;
        chk("clr_level", 64'(level), 64'(0));
        chk("clr_ov",    64'(ov),    64'(0));
        chk("clr_dout",  64'(dout),  64'(0));
        chk("clr_empty", 64'(empty), 64'(1));
        chk("clr_rfd",   64'(rfd),   64'(1));
        chk("clr_ovf",   64'(ovf),   64'(1));
        chk("clr_udf",   64'(udf),   64'(1));
        step();
        chk("clr_idle_level", 64'(level), 64'(0));
        chk("clr_idle_ov",    64'(ov),    64'(0));

        // same with rst: flags cleared too
        for (int i = 0; i < 2; i++) begin
            din = WIDTH'(36'h200 + i);
            iv  = 1'b1;
            step();
        end
        iv = 1'b0;
        chk("pre_rst_level", 64'(level), 64'(2));
        rst = 1'b1;
        iv  = 1'b1;
        step();
        rst = 1'b0;
        iv  = 1'b0;
        chk("rst2_level", 64'(level), 64'(0));
        chk("rst2_ov",    64'(ov),    64'(0));
        chk("rst2_dout",  64'(dout),  64'(0));
        chk("rst2_ovf",   64'(ovf),   64'(0));
        chk("rst2_udf",   64'(udf),   64'(0));
        chk("rst2_empty", 64'(empty), 64'(1));

        // usable again after reset
        din = 36'h0_0000_005A;
        iv  = 1'b1;
        step();
        iv  = 1'b0;
        step();
        chk("post_rst_ov",   64'(ov),   64'(1));
        chk("post_rst_dout", 64'(dout), 64'h05A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
